// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker
// Description : Receive end of the serial parity link. Deserialises
//               start-framed words arriving one bit per clock on D, then
//               recomputes XOR parity and compares it with the received
//               parity bit. Mismatches are flagged on ERR and counted in a
//               saturating counter.
//               Frame on D: start bit (1), DATA_BITS data bits LSB first,
//               then one parity bit. D idles at 0.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_BITS  : data bits per frame (>= 1)
//   PARITY_ODD : 0 = even parity (P = ^data), 1 = odd parity (P = ~^data)
//   CNT_W      : width of the saturating error counter
// Ports
//   C      in  1          clock, all state updates on posedge
//   R      in  1          asynchronous active-high reset
//   D      in  1          serial line
//   CLR    in  1          synchronous clear of ERRCNT
//   Q      out DATA_BITS  last received data word
//   VALID  out 1          one-cycle pulse, Q/ERR just updated
//   ERR    out 1          parity mismatch for the word in Q
//   BUSY   out 1          frame in progress
//   ERRCNT out CNT_W      saturating count of mismatched frames
// ============================================================================
module serial_parity_checker #(
  parameter int DATA_BITS  = 3,
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic                 C,
  input  logic                 R,
  input  logic                 D,
  input  logic                 CLR,
  output logic [DATA_BITS-1:0] Q,
  output logic                 VALID,
  output logic                 ERR,
  output logic                 BUSY,
  output logic [CNT_W-1:0]     ERRCNT
);

  // Index width is kept at least one bit so a single-bit frame still works.
  localparam int unsigned         IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] q_q, q_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 w_expected;
  logic                 w_par_bad;
  logic                 w_mismatch;

  // Parity the sender should have produced for the bits collected so far;
  // only meaningful while in S_PAR, when every data bit has been captured.
  assign w_expected = (^shreg_q) ^ PARITY_ODD;
  assign w_par_bad  = (D != w_expected);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    q_d        = q_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    w_mismatch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (D) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end

      S_DATA: begin
        // Bits arrive LSB first, so the running index is the bit position.
        shreg_d[idx_q] = D;
        if (idx_q == LAST_IDX) begin
          state_d = S_PAR;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_PAR: begin
        q_d        = shreg_q;
        valid_d    = 1'b1;
        err_d      = w_par_bad;
        w_mismatch = w_par_bad;
        // Return to idle so a start bit on the very next edge is accepted.
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Saturating error counter; a clear on the same edge as a mismatch wins.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (w_mismatch && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Q      = q_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;
  assign BUSY   = (state_q != S_IDLE);
  assign ERRCNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parity_checker
// Description : Scoreboard bench for serial_parity_checker. Two instances
//               share one serial line: an even-parity one with a 2-bit error
//               counter and an odd-parity one with an 8-bit counter. The
//               stimulus side pushes expected results per frame; monitors
//               pop and compare whenever a VALID pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_parity_checker;

  typedef struct {
    logic [2:0] q;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       d;
  logic       clr;

  logic [2:0] q_e, q_o;
  logic       valid_e, valid_o;
  logic       err_e, err_o;
  logic       busy_e, busy_o;
  logic [1:0] cnt_e;
  logic [7:0] cnt_o;

  exp_t       sb_e[$];
  exp_t       sb_o[$];

  int         tests_run;
  int         tests_failed;
  int         pushed;
  int         popped_e;
  int         popped_o;

  // reference counters held by the model
  int         m_cnt_e;
  int         m_cnt_o;

  serial_parity_checker #(
    .DATA_BITS (3),
    .PARITY_ODD(1'b0),
    .CNT_W     (2)
  ) u_even (
    .C     (clk),
    .R     (rst),
    .D     (d),
    .CLR   (clr),
    .Q     (q_e),
    .VALID (valid_e),
    .ERR   (err_e),
    .BUSY  (busy_e),
    .ERRCNT(cnt_e)
  );

  serial_parity_checker #(
    .DATA_BITS (3),
    .PARITY_ODD(1'b1),
    .CNT_W     (8)
  ) u_odd (
    .C     (clk),
    .R     (rst),
    .D     (d),
    .CLR   (clr),
    .Q     (q_o),
    .VALID (valid_o),
    .ERR   (err_o),
    .BUSY  (busy_o),
    .ERRCNT(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame's outcome from its data word, received parity
  // bit and whether CLR is raised on its parity edge.
  task automatic model_push(input logic [2:0] data, input logic p, input logic clr_at_par);
    int   ones;
    logic even_bad;
    logic odd_bad;
    exp_t e;
    exp_t o;
    ones = 0;
    for (int i = 0; i < 3; i++) ones += data[i];
    // even: bit makes total count of ones even; odd: makes it odd
    even_bad = (((ones + p) % 2) != 0);
    odd_bad  = (((ones + p) % 2) != 1);
    if (clr_at_par) begin
      m_cnt_e = 0;
      m_cnt_o = 0;
    end else begin
      if (even_bad && m_cnt_e < 3)   m_cnt_e++;
      if (odd_bad  && m_cnt_o < 255) m_cnt_o++;
    end
    e.q = data; e.err = even_bad; e.cnt = 8'(m_cnt_e);
    o.q = data; o.err = odd_bad;  o.cnt = 8'(m_cnt_o);
    sb_e.push_back(e);
    sb_o.push_back(o);
    pushed++;
  endtask

  // Drives one frame; returns right after the parity bit has been driven.
  task automatic send_frame(input logic [2:0] data, input logic p, input logic clr_at_par);
    @(negedge clk);
    d   = 1'b1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("busy_after_start_even", 32'(busy_e), 32'd1);
    check("busy_after_start_odd",  32'(busy_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = data[i];
    end
    @(negedge clk);
    d   = p;
    clr = clr_at_par;
    model_push(data, p, clr_at_par);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d   = 1'b0;
      clr = 1'b0;
      if (i == 0) begin
        check("busy_idle_even", 32'(busy_e), 32'd0);
        check("busy_idle_odd",  32'(busy_o), 32'd0);
      end
    end
  endtask

  task automatic clear_counters();
    @(negedge clk);
    d       = 1'b0;
    clr     = 1'b1;
    m_cnt_e = 0;
    m_cnt_o = 0;
    @(negedge clk);
    clr = 1'b0;
    check("clr_idle_even", 32'(cnt_e), 32'd0);
    check("clr_idle_odd",  32'(cnt_o), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q_even"},     32'(q_e),     32'd0);
    check({tag, "_err_even"},   32'(err_e),   32'd0);
    check({tag, "_valid_even"}, 32'(valid_e), 32'd0);
    check({tag, "_busy_even"},  32'(busy_e),  32'd0);
    check({tag, "_cnt_even"},   32'(cnt_e),   32'd0);
    check({tag, "_q_odd"},      32'(q_o),     32'd0);
    check({tag, "_err_odd"},    32'(err_o),   32'd0);
    check({tag, "_busy_odd"},   32'(busy_o),  32'd0);
    check({tag, "_cnt_odd"},    32'(cnt_o),   32'd0);
  endtask

  // Monitors: every VALID pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (!rst && valid_e) begin
      if (sb_e.size() == 0) begin
        check("unexpected_valid_even", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb_e.pop_front();
        popped_e++;
        check("q_even",   32'(q_e),   32'(x.q));
        check("err_even", 32'(err_e), 32'(x.err));
        check("cnt_even", 32'(cnt_e), 32'(x.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sb_o.size() == 0) begin
        check("unexpected_valid_odd", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb_o.pop_front();
        popped_o++;
        check("q_odd",   32'(q_o),   32'(x.q));
        check("err_odd", 32'(err_o), 32'(x.err));
        check("cnt_odd", 32'(cnt_o), 32'(x.cnt));
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pushed       = 0;
    popped_e     = 0;
    popped_o     = 0;
    m_cnt_e      = 0;
    m_cnt_o      = 0;
    rst          = 1'b1;
    d            = 1'b0;
    clr          = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    idle(2);

    // good even frame, then bad even frame
    send_frame(3'b101, 1'b0, 1'b0);
    idle(2);
    send_frame(3'b101, 1'b1, 1'b0);
    idle(2);

    // back-to-back frames with no idle gap
    send_frame(3'b110, 1'b0, 1'b0);
    send_frame(3'b111, 1'b1, 1'b0);
    idle(2);

    // saturation of the 2-bit counter, then clear on a bad frame's parity edge
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      send_frame(3'b011, 1'b1, 1'b0);
    end
    send_frame(3'b011, 1'b1, 1'b1);
    idle(2);

    // reset in the middle of a frame
    @(negedge clk);
    d = 1'b1;
    @(negedge clk);
    d = 1'b1;
    @(negedge clk);
    d = 1'b0;
    @(negedge clk);
    rst     = 1'b1;
    d       = 1'b0;
    m_cnt_e = 0;
    m_cnt_o = 0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    send_frame(3'b100, 1'b1, 1'b0);
    idle(2);

    // odd-parity reference cases
    send_frame(3'b000, 1'b1, 1'b0);
    idle(1);
    send_frame(3'b000, 1'b0, 1'b0);
    idle(2);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [2:0] data;
      logic       p;
      logic       c;
      int         gap;
      data = 3'($urandom_range(0, 7));
      p    = 1'($urandom_range(0, 1));
      c    = ($urandom_range(0, 9) == 0);
      gap  = $urandom_range(0, 2);
      send_frame(data, p, c);
      idle(gap);
    end
    idle(3);

    // bounded drain of the scoreboards
    for (int i = 0; i < 20 && (sb_e.size() != 0 || sb_o.size() != 0); i++) begin
      @(negedge clk);
    end
    check("drain_even", 32'(sb_e.size()), 32'd0);
    check("drain_odd",  32'(sb_o.size()), 32'd0);
    check("frames_seen_even", 32'(popped_e), 32'(pushed));
    check("frames_seen_odd",  32'(popped_o), 32'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
